// File: rtl/gf2m_pkg.sv
// Shared definitions for the GF(2^m) digit-serial multiplier:
// FSM state encoding, common field constants and the digit-count helper.
package gf2m_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    DONE = 2'b10
  } state_e;

  // NIST B-163 binary field: f(x) = x^163 + x^7 + x^6 + x^3 + 1
  localparam int           M_B163    = 163;
  localparam logic [162:0] POLY_B163 = 163'hC9;

  // AES field: f(x) = x^8 + x^4 + x^3 + x + 1
  localparam int           M_AES     = 8;
  localparam logic [7:0]   POLY_AES  = 8'h1B;

  // Number of DIGIT-wide slices needed to cover an m-bit multiplier.
  function automatic int calc_ndig(input int m, input int digit);
    return (m + digit - 1) / digit;
  endfunction

endpackage

// File: rtl/gf2m_digit_step.sv
// One clock's worth of the interleaved GF(2^m) multiply: consumes DIGIT
// bits of B, folding the running multiple of A into the accumulator and
// advancing A by x (with reduction) once per consumed bit.
module gf2m_digit_step
  import gf2m_pkg::*;
#(
  parameter int           M     = M_B163,
  parameter int           DIGIT = 4,
  parameter logic [M-1:0] POLY  = M'(POLY_B163)
) (
  input  logic [M-1:0]     a_in,
  input  logic [M-1:0]     acc_in,
  input  logic [DIGIT-1:0] b_digit,
  output logic [M-1:0]     a_out,
  output logic [M-1:0]     acc_out
);

  logic [M-1:0] w_a;
  logic [M-1:0] w_acc;

  // Unrolled chain: accumulate a_j where b bit j is set, then a_{j+1} = x*a_j mod f.
  always_comb begin
    w_a   = a_in;
    w_acc = acc_in;
    for (int j = 0; j < DIGIT; j++) begin
      if (b_digit[j]) begin
        w_acc = w_acc ^ w_a;
      end else begin
        w_acc = w_acc;
      end
      if (w_a[M-1]) begin
        w_a = (w_a << 1) ^ POLY;
      end else begin
        w_a = w_a << 1;
      end
    end
  end

  assign a_out   = w_a;
  assign acc_out = w_acc;

endmodule

// File: rtl/gf2m_digit_serial_mult.sv
// Digit-serial GF(2^M) polynomial-basis multiplier, Z = A*B mod f(x).
// B is consumed LSB-first, DIGIT bits per clock, over NDIG cycles.
// Handshake: start (IDLE only) -> busy for NDIG cycles -> one-cycle done with z.
// abort cancels a running operation without touching z.
// Optional feature macro GF2M_MAC_EN: adds port c and computes Z = A*B + C.
module gf2m_digit_serial_mult
  import gf2m_pkg::*;
#(
  parameter int           M     = M_B163,
  parameter int           DIGIT = 4,
  parameter logic [M-1:0] POLY  = M'(POLY_B163)
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic         abort,
`ifdef GF2M_MAC_EN
  input  logic [M-1:0] c,
`endif
  input  logic [M-1:0] a,
  input  logic [M-1:0] b,
  output logic [M-1:0] z,
  output logic         busy,
  output logic         done
);

  localparam int             NDIG     = calc_ndig(M, DIGIT);
  localparam int             CW       = $clog2(NDIG + 1);
  localparam logic [CW-1:0]  LAST_CNT = CW'(NDIG - 1);

  state_e        r_state;
  logic [M-1:0]  r_a;
  logic [M-1:0]  r_b;
  logic [M-1:0]  r_acc;
  logic [M-1:0]  r_z;
  logic [CW-1:0] r_cnt;
  logic          r_busy;
  logic          r_done;

  logic [M-1:0]  w_a_next;
  logic [M-1:0]  w_acc_next;
  logic [M-1:0]  w_acc_init;

`ifdef GF2M_MAC_EN
  assign w_acc_init = c;
`else
  assign w_acc_init = {M{1'b0}};
`endif

  gf2m_digit_step #(
    .M     (M),
    .DIGIT (DIGIT),
    .POLY  (POLY)
  ) u_step (
    .a_in    (r_a),
    .acc_in  (r_acc),
    .b_digit (r_b[DIGIT-1:0]),
    .a_out   (w_a_next),
    .acc_out (w_acc_next)
  );

  // Control FSM plus datapath registers; busy/done are registered alongside state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_a     <= {M{1'b0}};
      r_b     <= {M{1'b0}};
      r_acc   <= {M{1'b0}};
      r_z     <= {M{1'b0}};
      r_cnt   <= {CW{1'b0}};
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          r_done <= 1'b0;
          if (start) begin
            r_a     <= a;
            r_b     <= b;
            r_acc   <= w_acc_init;
            r_cnt   <= {CW{1'b0}};
            r_busy  <= 1'b1;
            r_state <= RUN;
          end else begin
            r_busy  <= 1'b0;
            r_state <= IDLE;
          end
        end
        RUN: begin
          r_done <= 1'b0;
          if (abort) begin
            r_busy  <= 1'b0;
            r_state <= IDLE;
          end else begin
            r_a   <= w_a_next;
            r_b   <= r_b >> DIGIT;
            r_acc <= w_acc_next;
            r_cnt <= r_cnt + CW'(1'b1);
            if (r_cnt == LAST_CNT) begin
              r_busy  <= 1'b0;
              r_state <= DONE;
            end else begin
              r_busy  <= 1'b1;
              r_state <= RUN;
            end
          end
        end
        DONE: begin
          r_z     <= r_acc;
          r_done  <= 1'b1;
          r_busy  <= 1'b0;
          r_state <= IDLE;
        end
        default: begin
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign z    = r_z;
  assign busy = r_busy;
  assign done = r_done;

endmodule

// File: doc/gf2m_digit_serial_mult.md
Name: gf2m_digit_serial_mult

Overview:
- Parametrised GF(2^M) polynomial-basis multiplier; computes Z = A·B mod f(x).
- Processes B LSB-first, DIGIT bits per clock; next generation of the 163-bit bit-serial interleaved multiplier.
- Sits in the ECC point-arithmetic datapath between the operand register file and the field-op sequencer.
- Adds: configurable field size, polynomial and digit size; a start/busy/done handshake; an explicit abort.

Parameters:
- M, 163, field degree; operand and result width.
- DIGIT, 4, B bits consumed per cycle; 1 ≤ DIGIT ≤ M.
- POLY, 163'hC9, low terms of f(x) (x^M implicit), M bits wide.
- NDIG, ceil(M/DIGIT), derived localparam: compute cycles per operation.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  request; sampled only in IDLE.
- abort  in  1  synchronous cancel of a running operation.
- a  in  M  multiplicand.
- b  in  M  multiplier.
- z  out  M  product; held stable after done.
- busy  out  1  high in RUN.
- done  out  1  one-cycle pulse when z is valid.

Behaviour:
- Reset (rst_n=0, async): state=IDLE; z=0, busy=0, done=0; internal regA/regB/acc/cnt=0. Reset mid-operation discards work; no done is produced.
- FSM states: IDLE, RUN, DONE.
  - IDLE → RUN on start=1: latch regA←a, regB←b, acc←0, cnt←0.
  - RUN → DONE when the cycle with cnt==NDIG-1 completes.
  - RUN → IDLE on abort=1: acc discarded; z keeps its previous value; no done.
  - DONE → IDLE unconditionally: z←acc, done=1 for exactly this cycle.
- Per RUN cycle, applied serially for j=0..DIGIT-1 as combinational logic:
  - if regB[j]: acc ^= a_j.
  - a_{j+1} = (a_j<<1)[M-1:0] ^ (a_j[M-1] ? POLY : 0).
  - a_0 = regA. At cycle end: regA←a_DIGIT, regB←regB>>DIGIT, cnt←cnt+1.
- Padding: when M % DIGIT ≠ 0, the final digit's upper bits are zero-shifted and contribute nothing.
- Latency: start accepted at edge 0; done asserted NDIG+1 cycles later. Throughput: one op per NDIG+2 cycles.
- start while busy or in DONE is ignored; no queuing.
- abort and start together in IDLE: start wins; abort is ignored outside RUN.
- cnt width is $clog2(NDIG+1); no wrap within one operation.
- Inputs a/b may change after the start cycle without affecting the result.
- busy = (state==RUN), registered-state decode.

Optional Feature:
- Macro GF2M_MAC_EN.
- Defined:
  - Extra input port c [M-1:0], latched with a and b; acc is initialised to c instead of 0, so z = A·B + C.
  - Zero latency cost.
- Undefined: port c is absent and acc is initialised to 0.

Decomposition:
- Package gf2m_pkg holds:
  - state enum (IDLE=2'b00, RUN=2'b01, DONE=2'b10);
  - default field constants M_B163=163, POLY_B163=163'hC9, M_AES=8, POLY_AES=8'h1B;
  - a function computing NDIG.
- Sub-module gf2m_digit_step (params M, DIGIT, POLY): purely combinational.
  - Inputs: a_in, acc_in, b_digit.
  - Outputs: a_out, acc_out.
  - Instantiated once; the top module holds the FSM, counter and registers.

Test Plan:
- M=8, DIGIT=1, POLY=8'h1B: a=8'h57, b=8'h83 → done 9 cycles after start, z=8'hC1.
- M=8, DIGIT=3 (padding), same operands → NDIG=3, done 4 cycles after start, z=8'hC1.
- Default M=163, DIGIT=4: a=1<<162, b=2 → z=163'hC9 after 42 cycles; a=1, b=1 → z=1.
- Random 500 operand pairs for DIGIT ∈ {1,4,7,163} vs software GF(2^163) model → exact match, busy high for exactly NDIG cycles.
- start re-pulsed during RUN → ignored, single done; abort at cnt=10 → busy drops next cycle, no done, z unchanged.
- rst_n low mid-RUN → z=0, busy=0, done=0 immediately. With GF2M_MAC_EN: a=8'h57, b=8'h83, c=8'h01 → z=8'hC0.
